calculator_core: RTL and testbench

Parametrised arithmetic engine sitting between the keyboard decoder and the multiplexed digit display. It accepts decoded digit/operator/submit pulses, builds two unsigned decimal operands of up to `DIGITS` digits, and computes add, subtract, multiply or divide with iterative shift-add/restoring datapaths. It then converts the result to BCD and presents it with sign and error flags. The display driver consumes `digits` directly.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/bin2bcd.sv | 74 +++++++
 rtl/calculator_core.sv | 225 ++++++++++++++++++++++
 tb/tb_calculator_core.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared operator codes, FSM state type and width helpers for the calculator core.
package calc_pkg;

   localparam logic [2:0] OPT_ADD = 3'd0;
   localparam logic [2:0] OPT_SUB = 3'd1;
   localparam logic [2:0] OPT_MUL = 3'd2;
   localparam logic [2:0] OPT_DIV = 3'd3;
   localparam logic [2:0] OPT_CLR = 3'd4;

   typedef enum logic [2:0] {
      StEntryA,
      StEntryB,
      StCompute,
      StConvert,
      StShow,
      StError
   } state_e;

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

   // Binary width able to hold any DIGITS-digit decimal value.
   function automatic int unsigned calc_width(input int unsigned digits);
      return $clog2(pow10(digits));
   endfunction

endpackage

// File: rtl/bin2bcd.sv
// Iterative double-dabble converter: one shift per cycle, W cycles from start to done.
module bin2bcd
   import calc_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   localparam int unsigned W = calc_width(DIGITS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [W-1:0]        bin,
   output logic [4*DIGITS-1:0] bcd,
   output logic                done
);

   localparam int unsigned CW = $clog2(W) + 1;

   logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
   logic [W-1:0]        sh_q, sh_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                run_q, run_d;
   logic                done_q, done_d;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end

      bcd_d  = bcd_q;
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_d = 1'b0;

      if (run_q) begin
         bcd_d = (4*DIGITS)'({adj, sh_q[W-1]});
         sh_d  = sh_q << 1;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end else if (start) begin
         // First iteration on an all-zero BCD register needs no adjust, so fold it into the load.
         bcd_d = (4*DIGITS)'(bin[W-1]);
         sh_d  = bin << 1;
         cnt_d = CW'(W - 1);
         run_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bcd_q  <= '0;
         sh_q   <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         bcd_q  <= bcd_d;
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign bcd  = bcd_q;
   assign done = done_q;

endmodule

// File: rtl/calculator_core.sv
// Keypad-driven four-function calculator: operand entry, iterative mul/div, BCD result display.
module calculator_core
   import calc_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          num,
   input  logic                numPressed,
   input  logic [2:0]          opt,
   input  logic                optPressed,
   input  logic                submit,
   output logic [4*DIGITS-1:0] digits,
   output logic                neg,
   output logic                err,
   output logic                busy
);

   localparam int unsigned         W          = calc_width(DIGITS);
   localparam int unsigned         CW         = $clog2(W) + 1;
   localparam logic [2*W-1:0]      Limit      = (2*W)'(pow10(DIGITS));
   localparam logic [W-1:0]        EntryMax   = W'(pow10(DIGITS - 1));
   localparam logic [4*DIGITS-1:0] ErrPattern = {DIGITS{4'hE}};

   state_e              state_q, state_d;
   logic [W-1:0]        a_q, a_d, b_q, b_d, entry_q, entry_d, res_q, res_d;
   logic [W-1:0]        mplr_q, mplr_d, rem_q, rem_d, quot_q, quot_d;
   logic [2*W-1:0]      prod_q, prod_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d, digits_q, digits_d;
   logic [2:0]          op_q, op_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                neg_res_q, neg_res_d, neg_q, neg_d, err_q, err_d;

   logic                clr, ev_sub, ev_op, ev_num, digit_ok, last;
   logic [W-1:0]        entry_next;
   logic [4*DIGITS-1:0] shadow_next;
   logic [2*W-1:0]      prod_step, result_wide;
   logic [W:0]          rem_sh;
   logic                div_ge;
   logic [W-1:0]        rem_step, quot_step;
   logic                b2b_start, b2b_done;
   logic [4*DIGITS-1:0] b2b_bcd;

   // Clear outranks everything and is honoured even while busy.
   assign clr    = optPressed && (opt == OPT_CLR);
   assign busy   = (state_q == StCompute) || (state_q == StConvert);
   assign ev_sub = submit && !optPressed && !busy || submit && !clr && !busy;
   assign ev_op  = optPressed && !submit && !busy && (opt <= OPT_DIV);
   assign ev_num = numPressed && !optPressed && !submit && !busy && (num <= 4'd9);

   assign digit_ok    = ev_num && (entry_q < EntryMax);
   assign entry_next  = (entry_q << 3) + (entry_q << 1) + W'(num);
   assign shadow_next = (4*DIGITS)'({shadow_q, num});

   assign prod_step = (prod_q << 1) + (mplr_q[W-1] ? (2*W)'(a_q) : '0);
   assign rem_sh    = {rem_q, quot_q[W-1]};
   assign div_ge    = rem_sh >= {1'b0, b_q};
   assign rem_step  = div_ge ? W'(rem_sh - {1'b0, b_q}) : rem_sh[W-1:0];
   assign quot_step = {quot_q[W-2:0], div_ge};

   always_comb begin
      result_wide = '0;
      last        = 1'b1;
      case (op_q)
         OPT_ADD: result_wide = (2*W)'(a_q) + (2*W)'(b_q);
         OPT_SUB: result_wide = (2*W)'((a_q >= b_q) ? a_q - b_q : b_q - a_q);
         OPT_MUL: begin
            result_wide = prod_step;
            last        = (cnt_q == CW'(W - 1));
         end
         OPT_DIV: begin
            result_wide = (2*W)'(quot_step);
            last        = (cnt_q == CW'(W - 1));
         end
         default: result_wide = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      entry_d   = entry_q;
      res_d     = res_q;
      mplr_d    = mplr_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      prod_d    = prod_q;
      shadow_d  = shadow_q;
      digits_d  = digits_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_d     = neg_q;
      err_d     = err_q;
      b2b_start = 1'b0;

      unique case (state_q)
         StEntryA, StEntryB: begin
            if (state_q == StEntryB && ev_sub) begin
               b_d     = entry_q;
               cnt_d   = '0;
               prod_d  = '0;
               mplr_d  = entry_q;
               rem_d   = '0;
               quot_d  = a_q;
               state_d = StCompute;
            end else if (ev_op) begin
               op_d = opt;
               if (state_q == StEntryA) begin
                  a_d      = entry_q;
                  entry_d  = '0;
                  shadow_d = '0;
                  state_d  = StEntryB;
               end
            end else if (digit_ok) begin
               entry_d  = entry_next;
               shadow_d = shadow_next;
               digits_d = shadow_next;
            end
         end
         StCompute: begin
            if (last) begin
               if (result_wide >= Limit || (op_q == OPT_DIV && b_q == '0)) begin
                  digits_d = ErrPattern;
                  err_d    = 1'b1;
                  neg_d    = 1'b0;
                  state_d  = StError;
               end else begin
                  b2b_start = 1'b1;
                  res_d     = result_wide[W-1:0];
                  neg_res_d = (op_q == OPT_SUB) && (a_q < b_q);
                  state_d   = StConvert;
               end
            end else begin
               cnt_d  = cnt_q + CW'(1);
               prod_d = prod_step;
               mplr_d = mplr_q << 1;
               rem_d  = rem_step;
               quot_d = quot_step;
            end
         end
         StConvert: begin
            if (b2b_done) begin
               digits_d = b2b_bcd;
               neg_d    = neg_res_q;
               err_d    = 1'b0;
               state_d  = StShow;
            end
         end
         StShow, StError: begin
            if (state_q == StShow && ev_op && !neg_q) begin
               a_d      = res_q;
               op_d     = opt;
               entry_d  = '0;
               shadow_d = '0;
               state_d  = StEntryB;
            end else if (ev_num) begin
               entry_d  = W'(num);
               shadow_d = (4*DIGITS)'(num);
               digits_d = (4*DIGITS)'(num);
               neg_d    = 1'b0;
               err_d    = 1'b0;
               state_d  = StEntryA;
            end
         end
         default: state_d = StEntryA;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         state_q   <= StEntryA;
         a_q       <= '0;
         b_q       <= '0;
         entry_q   <= '0;
         res_q     <= '0;
         mplr_q    <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         prod_q    <= '0;
         shadow_q  <= '0;
         digits_q  <= '0;
         op_q      <= OPT_ADD;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         entry_q   <= entry_d;
         res_q     <= res_d;
         mplr_q    <= mplr_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         prod_q    <= prod_d;
         shadow_q  <= shadow_d;
         digits_q  <= digits_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_q     <= neg_d;
         err_q     <= err_d;
      end
   end

   bin2bcd #(
      .DIGITS(DIGITS)
   ) u_bin2bcd (
      .clk  (clk),
      .reset(reset || clr),
      .start(b2b_start),
      .bin  (result_wide[W-1:0]),
      .bcd  (b2b_bcd),
      .done (b2b_done)
   );

   assign digits = digits_q;
   assign neg    = neg_q;
   assign err    = err_q;

endmodule

// File: tb/tb_calculator_core.sv
// Directed self-checking bench for calculator_core with DIGITS = 4.
module tb_calculator_core;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  num = '0;
   logic        numPressed = 1'b0;
   logic [2:0]  opt = '0;
   logic        optPressed = 1'b0;
   logic        submit = 1'b0;
   logic [15:0] digits;
   logic        neg, err, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int nb;

   calculator_core #(
      .DIGITS(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .num       (num),
      .numPressed(numPressed),
      .opt       (opt),
      .optPressed(optPressed),
      .submit    (submit),
      .digits    (digits),
      .neg       (neg),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic key(input int unsigned k);
      @(negedge clk);
      num        = 4'(k);
      numPressed = 1'b1;
      @(negedge clk);
      numPressed = 1'b0;
   endtask

   task automatic op(input int unsigned o);
      @(negedge clk);
      opt        = 3'(o);
      optPressed = 1'b1;
      @(negedge clk);
      optPressed = 1'b0;
   endtask

   task automatic eq();
      @(negedge clk);
      submit = 1'b1;
      @(negedge clk);
      submit = 1'b0;
   endtask

   task automatic type_num(input int unsigned v, input int nd);
      int unsigned p;
      for (int i = nd - 1; i >= 0; i--) begin
         p = 1;
         for (int j = 0; j < i; j++) p = p * 10;
         key((v / p) % 10);
      end
   endtask

   // Counts busy cycles sampled on falling edges; bounded so a stuck DUT still ends.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      do_reset();
      check("rst_digits", digits, 16'h0000);
      check("rst_neg", neg, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);

      key(1);
      key(12);
      check("digit_ignored", digits, 16'h0001);
      key(2);
      key(3);
      check("entry_123", digits, 16'h0123);
      key(4);
      key(5);
      check("entry_full", digits, 16'h1234);

      do_reset();
      type_num(12, 2); op(0); type_num(34, 2); eq();
      wait_idle(nb);
      check("add_busy", nb, 15);
      check("add_digits", digits, 16'h0046);
      check("add_neg", neg, 0);
      check("add_err", err, 0);
      op(0); key(4); eq();
      wait_idle(nb);
      check("chain_digits", digits, 16'h0050);

      do_reset();
      key(5); op(1); key(9);
      check("b_shown", digits, 16'h0009);
      eq();
      wait_idle(nb);
      check("sub_digits", digits, 16'h0004);
      check("sub_neg", neg, 1);
      op(0); eq();
      check("neg_op_ignored_busy", busy, 0);
      check("neg_op_ignored_digits", digits, 16'h0004);

      do_reset();
      type_num(99, 2); op(2); type_num(999, 3); eq();
      wait_idle(nb);
      check("ovf_busy", nb, 14);
      check("ovf_err", err, 1);
      check("ovf_digits", digits, 16'hEEEE);
      key(7);
      check("err_clear_err", err, 0);
      check("err_clear_digits", digits, 16'h0007);

      do_reset();
      type_num(100, 3); op(3); key(7); eq();
      wait_idle(nb);
      check("div_busy", nb, 28);
      check("div_digits", digits, 16'h0014);

      do_reset();
      key(7); op(3); key(0); eq();
      wait_idle(nb);
      check("div0_busy", nb, 14);
      check("div0_err", err, 1);

      do_reset();
      type_num(12, 2); op(2); type_num(34, 2); eq();
      repeat (19) @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_digits", digits, 16'h0034);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_digits", digits, 16'h0000);
      check("abort_neg", neg, 0);
      check("abort_err", err, 0);
      check("abort_busy", busy, 0);

      key(3); op(0); key(4);
      @(negedge clk);
      submit     = 1'b1;
      numPressed = 1'b1;
      num        = 4'd5;
      @(negedge clk);
      submit     = 1'b0;
      numPressed = 1'b0;
      wait_idle(nb);
      check("coincide_busy", nb, 15);
      check("coincide_digits", digits, 16'h0007);

      type_num(12, 2); op(0); type_num(34, 2); eq();
      repeat (2) @(negedge clk);
      op(4);
      check("clear_busy", busy, 0);
      check("clear_digits", digits, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
